// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
package fetch_pkg;

   localparam int ADDR_W  = 64;
   localparam int INSTR_W = 32;

   typedef enum logic {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs; flush wins over push and pop.
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [1:0]   count,
   output fetch_entry_t head
);

   fetch_entry_t mem_reg [2];
   logic         rd_ptr_reg;
   logic [1:0]   count_reg;
   logic         do_push;
   logic         do_pop;
   logic         wr_ptr;

   assign do_pop  = pop && (count_reg != 2'd0);
   assign do_push = push && ((count_reg != 2'd2) || do_pop);
   // With two slots, rd_ptr+count mod 2 lands on the popped slot when full
   assign wr_ptr  = rd_ptr_reg ^ count_reg[0];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_slot
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               mem_reg[gi] <= '0;
            end else if (do_push && !flush && (wr_ptr == 1'(gi))) begin
               mem_reg[gi] <= push_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else if (flush) begin
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign count = count_reg;
   assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with redirect, bounds fault and 2-deep output buffer.
// Optional macro FETCH_STATS_EN adds the saturating stall_cycles counter.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = 64'h0,
   parameter int                IMEM_SIZE = 1024
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [INSTR_W-1:0]  imem_instr,
   input  logic                redir_valid,
   input  logic [ADDR_W-1:0]   redir_target,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ADDR_W-1:0]   out_pc,
   output logic [INSTR_W-1:0]  out_instr,
`ifdef FETCH_STATS_EN
   output logic [31:0]         stall_cycles,
`endif
   output logic                fault
);

   generate
      if ((IMEM_SIZE <= 0) || ((IMEM_SIZE & (IMEM_SIZE - 1)) != 0)) begin : g_bad_size
         $error("fetch_unit: IMEM_SIZE must be a power of two");
      end
   endgenerate

   // pc+3 >= IMEM_SIZE rewritten so the compare cannot overflow
   localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(IMEM_SIZE) - 64'd3;

   fetch_state_t      state_reg;
   logic [ADDR_W-1:0] pc_reg;
   logic [1:0]        count;
   fetch_entry_t      head;
   fetch_entry_t      push_data;
   logic              pop;
   logic              pc_bad;
   logic              fetch;

   assign pop       = out_valid && out_ready;
   assign pc_bad    = (pc_reg[1:0] != 2'b00) || (pc_reg >= PC_LIMIT);
   assign fetch     = (state_reg == RUN) && !redir_valid && !pc_bad &&
                      ((count != 2'd2) || pop);
   assign push_data = '{pc: pc_reg, instr: imem_instr};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_reg    <= RESET_PC;
         state_reg <= RUN;
      end else if (redir_valid) begin
         pc_reg    <= redir_target;
         state_reg <= RUN;
      end else if ((state_reg == RUN) && pc_bad) begin
         state_reg <= FAULT;
      end else if (fetch) begin
         pc_reg <= pc_reg + 64'd4;
      end
   end

   fetch_buffer u_buffer (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fetch),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redir_valid),
      .count     (count),
      .head      (head)
   );

   assign imem_addr = pc_reg;
   assign out_valid = (count != 2'd0);
   assign out_pc    = head.pc;
   assign out_instr = head.instr;
   assign fault     = (state_reg == FAULT);

`ifdef FETCH_STATS_EN
   logic [31:0] stall_cycles_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles_reg <= 32'd0;
      end else if (out_valid && !out_ready && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
         stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the PC loaded on reset.
REQ-002 SHALL have parameter IMEM_SIZE, default 1024, the instruction ROM size in bytes; it SHALL be a power of two.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_addr, output, 64 bits: byte address to the combinational instruction ROM; equals the PC register.
REQ-006 SHALL have port imem_instr, input, 32 bits: ROM read data for imem_addr, valid in the same cycle.
REQ-007 SHALL have port redir_valid, input, 1 bit: a taken branch or redirect request this cycle.
REQ-008 SHALL have port redir_target, input, 64 bits: the redirect byte address.
REQ-009 SHALL have port out_valid, output, 1 bit: out_pc/out_instr hold a fetched instruction.
REQ-010 SHALL have port out_ready, input, 1 bit: the decode stage accepts this cycle.
REQ-011 SHALL have port out_pc, output, 64 bits: PC of the presented instruction.
REQ-012 SHALL have port out_instr, output, 32 bits: the presented instruction.
REQ-013 SHALL have port fault, output, 1 bit: high while in state FAULT.

Function
REQ-014 SHALL hold fetched {pc, instr} pairs in a 2-entry FIFO; out_* SHALL present the head entry, and out_valid SHALL be high when count>0.
REQ-015 SHALL pop the head on out_valid && out_ready; out_pc/out_instr SHALL be stable while out_valid && !out_ready.
REQ-016 SHALL fire a fetch when state==RUN && !redir_valid && (count<2 || pop); a fetch pushes {pc, imem_instr} and sets pc <= pc+4.
REQ-017 A simultaneous push and pop SHALL leave count unchanged, with the order preserved.
REQ-018 SHALL have FSM states RUN and FAULT.
REQ-019 RUN SHALL transition to FAULT, without fetching, when pc[1:0]!=0 or pc+3 >= IMEM_SIZE.
REQ-020 FAULT SHALL issue no fetches; the FIFO SHALL drain normally.
REQ-021 redir_valid SHALL have priority over everything else: count <= 0 (including any same-cycle pop), pc <= redir_target, state <= RUN, and no fetch that cycle.
REQ-022 A bad redir_target SHALL enter FAULT on the following cycle per REQ-019.
REQ-023 PC arithmetic SHALL be 64-bit unsigned; wrap at 2^64 is irrelevant because the bounds check faults first.
REQ-024 Fetch-to-out_valid latency SHALL be 1 cycle, so the first out_valid appears on the first edge after reset_n rises.

Reset
REQ-025 While reset_n==0: pc=RESET_PC, count=0, state=RUN, out_valid=0, fault=0, out_pc=0, out_instr=0; FIFO storage SHALL be cleared.
REQ-026 Reset asserted mid-operation SHALL discard all buffered entries immediately (asynchronously).

Configuration
REQ-027 Macro FETCH_STATS_EN SHALL, when defined, add output stall_cycles [31:0]: a saturating count of cycles with out_valid && !out_ready, reset to 0, not cleared by redirect.
REQ-028 Without FETCH_STATS_EN, the port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package fetch_pkg SHALL hold the ADDR_W=64 and INSTR_W=32 constants, the fetch_state_t enum {RUN, FAULT}, and the fetch_entry_t struct {pc, instr}.
REQ-030 The 2-entry FIFO SHALL be sub-module fetch_buffer (push, pop, flush, count, head), instantiated once.

Verification
REQ-031 Reset with RESET_PC=0 and out_ready=1 -> out_pc 0,4,8,12 on consecutive cycles, with out_instr equal to ROM words 0-3.
REQ-032 Hold out_ready=0 for 5 cycles -> count reaches 2, pc stops at 8, out_pc stays 0; release -> out_pc 0,4,8 with no gaps or duplicates.
REQ-033 redir_valid with target 0x40 while count=2 -> next cycle out_valid=0, pc=0x40; the following cycle out_pc=0x40.
REQ-034 Sequential run to pc=1020 with IMEM_SIZE=1024 -> entry 1020 delivered, then fault=1 and no further pushes; redirect to 0 -> fault=0 and fetching resumes.
REQ-035 Redirect to 0x42 -> fault=1 one cycle later with no entry pushed; reset_n pulse low mid-stream -> out_valid=0 immediately, restart at RESET_PC.
REQ-036 With FETCH_STATS_EN, 3 back-pressured cycles -> stall_cycles=3.
